// File: rtl/gray_step_generator.sv
// Gray-code stimulus source: a 4-bit up/down counter advanced by a
// prescaled free-run tick or a debounced single-step button.
module gray_step_generator #(
  parameter int PRESCALE        = 27000000,
  parameter int DEBOUNCE_CYCLES = 270000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run_sw,
  input  logic       step_btn,
  input  logic       dir,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       ag,
  output logic       bg,
  output logic       cg,
  output logic       dg,
  output logic [3:0] bin,
  output logic       step_pulse
);

  localparam int PW = $clog2(PRESCALE);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    IDLE_LO,
    WAIT_HI,
    IDLE_HI,
    WAIT_LO
  } db_e;

  logic          r_run_s1, r_run_s2;
  logic          r_dir_s1, r_dir_s2;
  logic          r_btn_s1, r_btn_s2;
  db_e           r_db;
  logic [DW-1:0] r_cnt;
  logic [PW-1:0] r_pre;
  logic [3:0]    r_bin;
  logic [3:0]    r_gray;
  logic          r_pulse;

  logic          w_run, w_dir, w_btn;
  logic          w_tick, w_step_req, w_adv;
  logic [3:0]    w_next;

  assign w_run = r_run_s2;
  assign w_dir = r_dir_s2;
  assign w_btn = r_btn_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run_s1 <= 1'b0;
      r_run_s2 <= 1'b0;
      r_dir_s1 <= 1'b0;
      r_dir_s2 <= 1'b0;
      r_btn_s1 <= 1'b0;
      r_btn_s2 <= 1'b0;
    end else begin
      r_run_s1 <= run_sw;
      r_run_s2 <= r_run_s1;
      r_dir_s1 <= dir;
      r_dir_s2 <= r_dir_s1;
      r_btn_s1 <= step_btn;
      r_btn_s2 <= r_btn_s1;
    end
  end

  // The state itself holds the accepted button level (IDLE_HI/WAIT_LO = high).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_db  <= IDLE_LO;
      r_cnt <= '0;
    end else begin
      unique case (r_db)
        IDLE_LO: begin
          if (w_btn) begin
            r_db  <= WAIT_HI;
            r_cnt <= DW'(1);
          end
        end
        WAIT_HI: begin
          if (!w_btn) begin
            r_db  <= IDLE_LO;
            r_cnt <= '0;
          end else if (r_cnt == DMAX) begin
            r_db  <= IDLE_HI;
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        IDLE_HI: begin
          if (!w_btn) begin
            r_db  <= WAIT_LO;
            r_cnt <= DW'(1);
          end
        end
        WAIT_LO: begin
          if (w_btn) begin
            r_db  <= IDLE_HI;
            r_cnt <= '0;
          end else if (r_cnt == DMAX) begin
            r_db  <= IDLE_LO;
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign w_step_req = (r_db == WAIT_HI) && w_btn && (r_cnt == DMAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= '0;
    end else if (!w_run || r_pre == PMAX) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

  assign w_tick = w_run && (r_pre == PMAX);

  always_comb begin
    w_adv  = w_run ? w_tick : w_step_req;
    w_next = r_bin;
    if (load) begin
      w_next = load_val;
    end else if (w_adv) begin
      w_next = w_dir ? r_bin - 4'd1 : r_bin + 4'd1;
    end
  end

  // Gray is encoded from the next count so bin and gray move together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin   <= 4'd0;
      r_gray  <= 4'd0;
      r_pulse <= 1'b0;
    end else begin
      r_bin   <= w_next;
      r_gray  <= w_next ^ (w_next >> 1);
      r_pulse <= load | w_adv;
    end
  end

  assign bin        = r_bin;
  assign ag         = r_gray[3];
  assign bg         = r_gray[2];
  assign cg         = r_gray[1];
  assign dg         = r_gray[0];
  assign step_pulse = r_pulse;

endmodule

// File: tb/tb_gray_step_generator.sv
// Bench for gray_step_generator: directed phases with literal
// expectations plus random stimulus against a run-length reference model.
module tb_gray_step_generator;

  localparam int P = 4;
  localparam int D = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run_sw = 1'b0;
  logic       step_btn = 1'b0;
  logic       dir = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic       ag, bg, cg, dg;
  logic [3:0] bin;
  logic       step_pulse;

  int n_cmp = 0;
  int n_bad = 0;
  int n_pulse = 0;

  int gt[16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};

  gray_step_generator #(
    .PRESCALE(P),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .run_sw(run_sw),
    .step_btn(step_btn),
    .dir(dir),
    .load(load),
    .load_val(load_val),
    .ag(ag),
    .bg(bg),
    .cg(cg),
    .dg(dg),
    .bin(bin),
    .step_pulse(step_pulse)
  );

  always #5 clk = ~clk;

  function automatic int gray();
    return int'({ag, bg, cg, dg});
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_pulse(output int n);
    n = 0;
    do begin
      cyc(1);
      n++;
    end while (!step_pulse && n < 40);
    chk("pulse_wait", int'(step_pulse), 1);
  endtask

  // Reference model: synced inputs are raw inputs two edges old; a tick
  // fires every P-th cycle of synced run, a step when synced btn has been
  // high for D+1 cycles while the accepted level is low.
  initial begin : model
    logic q1r, q2r, q1d, q2d, q1b, q2b;
    logic lb, acc, tick, req, adv;
    logic [3:0] m_bin;
    logic m_pulse;
    int rl, bl;
    q1r = 0; q2r = 0; q1d = 0; q2d = 0; q1b = 0; q2b = 0;
    lb = 0; acc = 0; m_bin = 0; m_pulse = 0; rl = 0; bl = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q1r = 0; q2r = 0; q1d = 0; q2d = 0; q1b = 0; q2b = 0;
        lb = 0; acc = 0; m_bin = 0; m_pulse = 0; rl = 0; bl = 0;
        chk("rst_bin", int'(bin), 0);
        chk("rst_gray", gray(), 0);
        chk("rst_pulse", int'(step_pulse), 0);
      end else begin
        chk("m_bin", int'(bin), int'(m_bin));
        chk("m_gray", gray(), int'(m_bin ^ (m_bin >> 1)));
        chk("m_pulse", int'(step_pulse), int'(m_pulse));
        if (step_pulse) n_pulse++;
        rl = q2r ? rl + 1 : 0;
        tick = q2r && (rl % P == 0);
        if (q2b == lb) bl++;
        else begin
          bl = 1;
          lb = q2b;
        end
        req = 0;
        if (q2b != acc && bl == D + 1) begin
          req = q2b;
          acc = q2b;
        end
        adv = q2r ? tick : req;
        if (load) m_bin = load_val;
        else if (adv) m_bin = q2d ? m_bin - 4'd1 : m_bin + 4'd1;
        m_pulse = load | adv;
        q2r = q1r; q1r = run_sw;
        q2d = q1d; q1d = dir;
        q2b = q1b; q1b = step_btn;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n, b0, p0, prev;
    // Reset with random inputs
    rst_n = 0;
    repeat (5) begin
      run_sw = 1'($urandom);
      dir = 1'($urandom);
      step_btn = 1'($urandom);
      load = 1'($urandom);
      load_val = 4'($urandom);
      cyc(1);
    end
    run_sw = 1; dir = 0; step_btn = 0; load = 0; load_val = 0;
    cyc(1);
    rst_n = 1;
    chk("rel_bin", int'(bin), 0);
    chk("rel_gray", gray(), 0);
    chk("rel_pulse", int'(step_pulse), 0);
    n = 0;
    while (bin != 4'd7 && n < 100) begin
      cyc(1);
      n++;
    end
    chk("reach7", int'(bin), 7);
    #2 rst_n = 0;
    #1;
    chk("async_bin", int'(bin), 0);
    chk("async_gray", gray(), 0);
    chk("async_pulse", int'(step_pulse), 0);
    cyc(2);
    rst_n = 1;

    // Free-run up through the whole code wheel
    prev = 0;
    for (int k = 1; k <= 16; k++) begin
      wait_pulse(n);
      chk("up_bin", int'(bin), k % 16);
      chk("up_gray", gray(), gt[k % 16]);
      chk("up_onebit", $countones(gray() ^ prev), 1);
      if (k > 1) chk("up_period", n, P);
      prev = gray();
    end

    // Load then free-run down
    run_sw = 0;
    cyc(4);
    load = 1; load_val = 4'd1;
    cyc(1);
    load = 0;
    chk("ld_bin", int'(bin), 1);
    chk("ld_gray", gray(), 1);
    chk("ld_pulse", int'(step_pulse), 1);
    dir = 1; run_sw = 1;
    wait_pulse(n);
    chk("dn_bin0", int'(bin), 0);
    chk("dn_gray0", gray(), 0);
    wait_pulse(n);
    chk("dn_bin15", int'(bin), 15);
    chk("dn_gray15", gray(), 8);
    wait_pulse(n);
    chk("dn_bin14", int'(bin), 14);
    chk("dn_gray14", gray(), 9);

    // Debounce in single-step mode
    run_sw = 0; dir = 0;
    cyc(4);
    load = 1; load_val = 4'd0;
    cyc(1);
    load = 0;
    cyc(2);
    p0 = n_pulse;
    step_btn = 1; cyc(2);
    step_btn = 0; cyc(1);
    step_btn = 1; cyc(2);
    step_btn = 0; cyc(6);
    chk("bounce_bin", int'(bin), 0);
    chk("bounce_pulses", n_pulse - p0, 0);
    step_btn = 1; cyc(10);
    chk("press_bin", int'(bin), 1);
    chk("press_gray", gray(), 1);
    chk("press_pulses", n_pulse - p0, 1);
    step_btn = 0; cyc(1);
    step_btn = 1; cyc(1);
    step_btn = 0; cyc(1);
    step_btn = 1; cyc(1);
    step_btn = 0; cyc(10);
    chk("release_bin", int'(bin), 1);
    chk("release_pulses", n_pulse - p0, 1);

    // Load collides with a tick
    run_sw = 1;
    wait_pulse(n);
    cyc(3);
    load = 1; load_val = 4'd10;
    cyc(1);
    load = 0;
    chk("prio_bin", int'(bin), 10);
    chk("prio_gray", gray(), 15);
    chk("prio_pulse", int'(step_pulse), 1);
    cyc(1);
    chk("prio_single", int'(step_pulse), 0);
    step_btn = 1;
    p0 = n_pulse;
    cyc(16);
    chk("runbtn_pulses", n_pulse - p0, 4);
    chk("runbtn_bin", int'(bin), 14);
    step_btn = 0;
    cyc(8);

    // Run switch latency and mid-prescale stop
    run_sw = 0;
    cyc(8);
    run_sw = 1;
    wait_pulse(n);
    chk("run_latency", n, 6);
    cyc(1);
    run_sw = 0;
    p0 = n_pulse;
    b0 = int'(bin);
    cyc(12);
    chk("stop_pulses", n_pulse - p0, 0);
    chk("stop_bin", int'(bin), b0);
    run_sw = 1;
    wait_pulse(n);
    chk("rerun_latency", n, 6);

    // Random stimulus, checked every cycle by the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(39) == 0) run_sw = ~run_sw;
      if ($urandom_range(9) == 0) dir = ~dir;
      if ($urandom_range(5) == 0) step_btn = ~step_btn;
      load = ($urandom_range(29) == 0);
      load_val = 4'($urandom);
      cyc(1);
    end
    load = 0;
    cyc(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
